// File: rtl/anthem_sequencer.sv
// anthem_sequencer: walks the character ROM and paces ASCII text onto the
// character output, inserting blank gaps at word separators, with single-word and loop play.
module anthem_sequencer #(
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] TICK_DIV  = 16'd50000,
  parameter int          GAP_CHARS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [2:0]        word_sel,
  input  logic              loop_en,
  input  logic [3:0]        rate,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, SCAN, FETCH, WAIT, EMIT, GAP, END_GAP} state_t;

  localparam logic [7:0]        SPACE     = 8'h20;
  localparam logic [7:0]        NUL       = 8'h00;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [15:0]       TICK_LAST = TICK_DIV - 16'd1;
  localparam logic [15:0]       GAP_MULT  = 16'(GAP_CHARS);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        char_reg, char_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic              start_sync_reg, start_prev_reg;
  logic              mode_reg, mode_next;
  logic [2:0]        word_sel_reg, word_sel_next;
  logic [2:0]        word_cnt_reg, word_cnt_next;
  logic              scan_phase_reg, scan_phase_next;
  logic [15:0]       presc_reg, presc_next;
  logic [15:0]       hold_reg, hold_next;
  logic [15:0]       hold_tgt_reg, hold_tgt_next;
  logic              tick, hold_done, start_edge;
  logic              launch, end_evt, load_char, load_gap;
  logic [15:0]       char_tgt, gap_tgt;

  assign tick       = (presc_reg == TICK_LAST);
  assign hold_done  = tick && (hold_reg == hold_tgt_reg);
  assign start_edge = start_sync_reg && !start_prev_reg;
  // Hold targets are stored as (ticks - 1) so the terminal compare is a plain equality.
  assign char_tgt   = {12'd0, rate};
  assign gap_tgt    = GAP_MULT * (char_tgt + 16'd1) - 16'd1;

  assign rom_addr   = addr_reg;
  assign char_out   = char_reg;
  assign char_valid = valid_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    char_next       = char_reg;
    valid_next      = 1'b0;
    done_next       = 1'b0;
    mode_next       = mode_reg;
    word_sel_next   = word_sel_reg;
    word_cnt_next   = word_cnt_reg;
    scan_phase_next = scan_phase_reg;
    presc_next      = (state_reg == IDLE || tick) ? 16'd0 : presc_reg + 16'd1;
    hold_next       = tick ? hold_reg + 16'd1 : hold_reg;
    hold_tgt_next   = hold_tgt_reg;
    launch          = 1'b0;
    end_evt         = 1'b0;
    load_char       = 1'b0;
    load_gap        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          mode_next     = mode;
          word_sel_next = word_sel;
          launch        = 1'b1;
        end
      end
      SCAN: begin
        if (!scan_phase_reg) begin
          scan_phase_next = 1'b1;
        end else begin
          scan_phase_next = 1'b0;
          if (rom_data == NUL || addr_reg == LAST_ADDR) begin
            end_evt = 1'b1;
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
            if (rom_data == SPACE) begin
              word_cnt_next = word_cnt_reg + 3'd1;
              if (word_cnt_reg + 3'd1 == word_sel_reg) state_next = FETCH;
            end
          end
        end
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        if (rom_data == NUL || (rom_data == SPACE && mode_reg)) begin
          end_evt = 1'b1;
        end else if (rom_data == SPACE) begin
          state_next = GAP;
          char_next  = NUL;
          valid_next = 1'b1;
          load_gap   = 1'b1;
        end else begin
          state_next = EMIT;
          char_next  = rom_data;
          valid_next = 1'b1;
          load_char  = 1'b1;
        end
      end
      EMIT, GAP: begin
        if (hold_done) begin
          if (addr_reg == LAST_ADDR) begin
            end_evt = 1'b1;
          end else begin
            addr_next  = addr_reg + ADDR_W'(1);
            state_next = FETCH;
          end
        end
      end
      END_GAP: if (hold_done) launch = 1'b1;
      default: state_next = IDLE;
    endcase

    // A blank after a blank is not a new value, so no pulse in that case.
    if (end_evt) begin
      char_next  = NUL;
      valid_next = (char_reg != NUL);
      if (loop_en) begin
        state_next = END_GAP;
        load_gap   = 1'b1;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
        addr_next  = '0;
      end
    end

    if (load_char || load_gap) begin
      presc_next    = 16'd0;
      hold_next     = 16'd0;
      hold_tgt_next = load_gap ? gap_tgt : char_tgt;
    end

    if (launch) begin
      addr_next       = '0;
      word_cnt_next   = 3'd0;
      scan_phase_next = 1'b0;
      presc_next      = 16'd0;
      hold_next       = 16'd0;
      state_next      = (mode_next && word_sel_next != 3'd0) ? SCAN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      char_reg       <= NUL;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
      start_sync_reg <= 1'b0;
      start_prev_reg <= 1'b0;
      mode_reg       <= 1'b0;
      word_sel_reg   <= 3'd0;
      word_cnt_reg   <= 3'd0;
      scan_phase_reg <= 1'b0;
      presc_reg      <= 16'd0;
      hold_reg       <= 16'd0;
      hold_tgt_reg   <= 16'd0;
    end else if (abort) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      char_reg       <= NUL;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
      start_sync_reg <= start;
      start_prev_reg <= start_sync_reg;
      word_cnt_reg   <= 3'd0;
      scan_phase_reg <= 1'b0;
      presc_reg      <= 16'd0;
      hold_reg       <= 16'd0;
    end else if (ena) begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      char_reg       <= char_next;
      valid_reg      <= valid_next;
      done_reg       <= done_next;
      start_sync_reg <= start;
      start_prev_reg <= start_sync_reg;
      mode_reg       <= mode_next;
      word_sel_reg   <= word_sel_next;
      word_cnt_reg   <= word_cnt_next;
      scan_phase_reg <= scan_phase_next;
      presc_reg      <= presc_next;
      hold_reg       <= hold_next;
      hold_tgt_reg   <= hold_tgt_next;
    end else begin
      // Frozen: pulses must not repeat while the rest of the state holds.
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_anthem_sequencer.sv
// Testbench for anthem_sequencer: a ROM model plus a queue of expected characters
// that a negedge monitor pops and compares on each char_valid pulse.
module tb_anthem_sequencer;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mode = 1'b0;
  logic [2:0]        word_sel = 3'd0;
  logic              loop_en = 1'b0;
  logic [3:0]        rate = 4'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [7:0]        char_out;
  logic              char_valid, busy, done;

  logic [7:0] rom [64];
  logic [7:0] exp_q [$];
  int         vcyc [$];
  logic [7:0] mon_exp;
  int tests_run = 0, tests_failed = 0;
  int cyc = 0, done_cnt = 0, valid_cnt = 0;

  anthem_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(16'd4), .GAP_CHARS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .mode(mode), .word_sel(word_sel), .loop_en(loop_en), .rate(rate),
    .rom_addr(rom_addr), .rom_data(rom_data), .char_out(char_out),
    .char_valid(char_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  always @(negedge clk) begin
    if (char_valid) begin
      valid_cnt++;
      vcyc.push_back(cyc);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_char: got %02h at cycle %0d, required no pulse", char_out, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (char_out !== mon_exp) begin
          tests_failed++;
          $display("FAIL char_value: got %02h, required %02h", char_out, mon_exp);
        end
        $display("[TB] cycle %0d char %02h", cyc, char_out);
      end
    end
    if (done) begin
      done_cnt++;
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_busy: busy=%b with done, required 0", busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic prep(input string s);
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    exp_q.delete();
    vcyc.delete();
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (valid_cnt < target) begin
      tests_failed++;
      $display("FAIL %s_wait_valid: got %0d pulses, required %0d", name, valid_cnt, target);
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tick(20);
    tests_run++;
    if (done_cnt != target) begin
      tests_failed++;
      $display("FAIL %s_done: got %0d done pulses, required %0d", name, done_cnt, target);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_chars: %0d expected chars never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    tests_run += 5;
    if (rom_addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %0d, required 0", rom_addr); end
    if (char_out !== 8'h00) begin tests_failed++; $display("FAIL reset_char: got %02h, required 00", char_out); end
    if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", char_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", done); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_full_text();
    int t0;
    prep("AB C");
    mode = 1'b0; rate = 4'd0; loop_en = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h00);
    exp_q.push_back(8'h43); exp_q.push_back(8'h00);
    t0 = cyc + 1;
    launch();
    wait_done(1, 200, "full");
    tests_run += 3;
    if (vcyc.size() < 5 || vcyc[0] - t0 != 3) begin
      tests_failed++; $display("FAIL full_latency: got %0d cycles, required 3", vcyc[0] - t0);
    end
    if (vcyc.size() < 5 || vcyc[1] - vcyc[0] != 6) begin
      tests_failed++; $display("FAIL full_spacing: got %0d cycles, required 6", vcyc[1] - vcyc[0]);
    end
    if (vcyc.size() < 5 || vcyc[3] - vcyc[2] != 10) begin
      tests_failed++; $display("FAIL full_gap: got %0d cycles, required 10", vcyc[3] - vcyc[2]);
    end
  endtask

  task automatic test_word();
    prep("Tacana Fuego Agua");
    mode = 1'b1; word_sel = 3'd2; rate = 4'd0; loop_en = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h67); exp_q.push_back(8'h75);
    exp_q.push_back(8'h61); exp_q.push_back(8'h00);
    launch();
    wait_done(1, 400, "word2");
    prep("Tacana Fuego Agua");
    word_sel = 3'd5;
    launch();
    wait_done(1, 400, "word5");
    tests_run++;
    if (valid_cnt != 0) begin
      tests_failed++; $display("FAIL word5_silent: got %0d pulses, required 0", valid_cnt);
    end
    mode = 1'b0; word_sel = 3'd0;
  endtask

  task automatic test_loop();
    prep("AB");
    rate = 4'd0; loop_en = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h00);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h00);
    launch();
    wait_valid(4, 200, "loop");
    loop_en = 1'b0;
    wait_done(1, 200, "loop");
    tests_run++;
    if (vcyc.size() < 4 || vcyc[3] - vcyc[2] != 10) begin
      tests_failed++; $display("FAIL loop_gap: got %0d cycles, required 10", vcyc[3] - vcyc[2]);
    end
  endtask

  task automatic test_rate_ena();
    prep("XY");
    rate = 4'd3;
    exp_q.push_back(8'h58); exp_q.push_back(8'h59); exp_q.push_back(8'h00);
    launch();
    wait_valid(2, 200, "rate");
    tick(5);
    ena = 1'b0;
    tick(7);
    ena = 1'b1;
    wait_done(1, 300, "rate");
    tests_run += 2;
    if (vcyc.size() < 3 || vcyc[1] - vcyc[0] != 18) begin
      tests_failed++; $display("FAIL rate_spacing: got %0d cycles, required 18", vcyc[1] - vcyc[0]);
    end
    if (vcyc.size() < 3 || vcyc[2] - vcyc[1] != 25) begin
      tests_failed++; $display("FAIL ena_stretch: got %0d cycles, required 25", vcyc[2] - vcyc[1]);
    end
    rate = 4'd0;
  endtask

  task automatic test_abort();
    prep("A BC");
    exp_q.push_back(8'h41); exp_q.push_back(8'h00);
    launch();
    wait_valid(2, 200, "abort");
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tests_run += 2;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (char_out !== 8'h00) begin tests_failed++; $display("FAIL abort_char: got %02h, required 00", char_out); end
    tick(40);
    tests_run += 2;
    if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_done: got %0d, required 0", done_cnt); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL abort_chars: %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_emit();
    prep("A BC");
    rate = 4'd1;
    exp_q.push_back(8'h41);
    launch();
    wait_valid(1, 200, "rstemit");
    tick(1);
    rst_n = 1'b0;
    tick(1);
    tests_run += 2;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstemit_busy: got %b, required 0", busy); end
    if (char_out !== 8'h00) begin tests_failed++; $display("FAIL rstemit_char: got %02h, required 00", char_out); end
    rst_n = 1'b1;
    tick(40);
    tests_run++;
    if (done_cnt != 0) begin tests_failed++; $display("FAIL rstemit_done: got %0d, required 0", done_cnt); end
    rate = 4'd0;
  endtask

  task automatic test_back_to_back();
    prep("AB");
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h00);
    launch();
    wait_valid(1, 200, "b2b");
    launch();
    wait_done(1, 200, "b2b");
    tick(20);
    tests_run += 2;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got %b, required 0", busy); end
    if (valid_cnt != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d pulses, required 3", valid_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    test_reset();
    test_full_text();
    test_word();
    test_loop();
    test_rate_ena();
    test_abort();
    test_reset_emit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
